// File: rtl/alu_operand_stage_pkg.sv
// alu_operand_stage_pkg: widths, opcode constants and the operand-register record shared with the ALU.
package alu_operand_stage_pkg;
    localparam int DATA_W = 8;
    localparam int OP_W   = 5;
    localparam int NREGS  = 8;
    localparam int ADDR_W = $clog2(NREGS);
    localparam logic [OP_W-1:0] OP_ADD = 5'd0;
    localparam logic [OP_W-1:0] OP_SUB = 5'd1;
    localparam logic [OP_W-1:0] OP_AND = 5'd2;
    localparam logic [OP_W-1:0] OP_OR  = 5'd3;
    localparam logic [OP_W-1:0] OP_XOR = 5'd4;
    localparam logic [OP_W-1:0] OP_MUL = 5'd5;
    localparam logic [OP_W-1:0] OP_DIV = 5'd6;
    typedef struct packed {
        logic [DATA_W-1:0] in1;
        logic [DATA_W-1:0] in2;
        logic [OP_W-1:0]   sel;
        logic [ADDR_W-1:0] rd;
        logic              dz;
    } alu_op_t;
endpackage

// File: rtl/alu_regfile.sv
// alu_regfile: NREGS x DATA_W register file, two async read ports, one sync write port, async clear.
module alu_regfile
    import alu_operand_stage_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr1_i,
    input  logic [ADDR_W-1:0] raddr2_i,
    output logic [DATA_W-1:0] rdata1_o,
    output logic [DATA_W-1:0] rdata2_o
);
    logic [DATA_W-1:0] regs_q [NREGS];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else if (we_i) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end
    assign rdata1_o = regs_q[raddr1_i];
    assign rdata2_o = regs_q[raddr2_i];
endmodule

// File: rtl/alu_operand_stage.sv
// alu_operand_stage: register-file read plus one pipeline register feeding the ALU.
// ALU_BYPASS_EN: forward same-cycle writeback into operands instead of stalling.
module alu_operand_stage
    import alu_operand_stage_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_op,
    input  logic [ADDR_W-1:0] in_rd,
    input  logic [ADDR_W-1:0] in_rs1,
    input  logic [ADDR_W-1:0] in_rs2,
    input  logic              in_use_imm,
    input  logic [DATA_W-1:0] in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] alu_in1,
    output logic [DATA_W-1:0] alu_in2,
    output logic [OP_W-1:0]   alu_sel,
    output logic [ADDR_W-1:0] out_rd,
    output logic              out_dz,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data
);
    logic [DATA_W-1:0] rdata1, rdata2, opa, opb;
    logic rs1_hit, rs2_hit, stall, load, valid_d, valid_q;
    alu_op_t op_d, op_q;
    alu_regfile u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .we_i     (wb_en),
        .waddr_i  (wb_addr),
        .wdata_i  (wb_data),
        .raddr1_i (in_rs1),
        .raddr2_i (in_rs2),
        .rdata1_o (rdata1),
        .rdata2_o (rdata2)
    );
    assign rs1_hit = wb_en && wb_addr == in_rs1;
    assign rs2_hit = wb_en && !in_use_imm && wb_addr == in_rs2;
`ifdef ALU_BYPASS_EN
    assign opa   = rs1_hit ? wb_data : rdata1;
    assign opb   = in_use_imm ? in_imm : (rs2_hit ? wb_data : rdata2);
    assign stall = 1'b0;
`else
    // Read ports return the pre-write value, so hold off until the write lands.
    assign opa   = rdata1;
    assign opb   = in_use_imm ? in_imm : rdata2;
    assign stall = rs1_hit | rs2_hit;
`endif
    assign in_ready = (!valid_q | out_ready) & !stall;
    assign load     = in_valid & in_ready;
    assign valid_d  = load | (valid_q & !out_ready);
    always_comb begin
        op_d     = '0;
        op_d.in1 = opa;
        op_d.in2 = opb;
        op_d.sel = in_op;
        op_d.rd  = in_rd;
        op_d.dz  = in_op == OP_DIV && opb == '0;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            op_q    <= '0;
        end else begin
            valid_q <= valid_d;
            if (load) op_q <= op_d;
        end
    end
    assign out_valid = valid_q;
    assign alu_in1   = op_q.in1;
    assign alu_in2   = op_q.in2;
    assign alu_sel   = op_q.sel;
    assign out_rd    = op_q.rd;
    assign out_dz    = op_q.dz;
endmodule

// File: tb/tb_alu_operand_stage.sv
// tb_alu_operand_stage: directed scoreboard bench for alu_operand_stage (both ALU_BYPASS_EN builds).
module tb_alu_operand_stage;
    import alu_operand_stage_pkg::*;
    logic clk = 1'b0;
    logic rst_n, in_valid, in_ready, in_use_imm, out_valid, out_ready, out_dz, wb_en;
    logic [OP_W-1:0] in_op, alu_sel;
    logic [ADDR_W-1:0] in_rd, in_rs1, in_rs2, out_rd, wb_addr;
    logic [DATA_W-1:0] in_imm, alu_in1, alu_in2, wb_data;
    logic [DATA_W-1:0] m [NREGS];
    alu_op_t q [$];
    alu_op_t cur;
    int total = 0;
    int bad = 0;

    alu_operand_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_use_imm(in_use_imm), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready), .alu_in1(alu_in1), .alu_in2(alu_in2),
        .alu_sel(alu_sel), .out_rd(out_rd), .out_dz(out_dz), .wb_en(wb_en), .wb_addr(wb_addr),
        .wb_data(wb_data)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wb(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        wb_en = 1'b1; wb_addr = a; wb_data = d;
        m[a] = d;
        tick();
        wb_en = 1'b0;
    endtask

    function automatic alu_op_t mk(input logic [OP_W-1:0] op, input logic [ADDR_W-1:0] rs1,
                                   input logic [ADDR_W-1:0] rs2, input logic [ADDR_W-1:0] rd,
                                   input logic ui, input logic [DATA_W-1:0] imm);
        alu_op_t e;
        e.in1 = m[rs1];
        e.in2 = ui ? imm : m[rs2];
        e.sel = op;
        e.rd  = rd;
        e.dz  = (op == OP_DIV) && (e.in2 == 8'h00);
        return e;
    endfunction

    task automatic drive(input logic [OP_W-1:0] op, input logic [ADDR_W-1:0] rs1,
                         input logic [ADDR_W-1:0] rs2, input logic [ADDR_W-1:0] rd,
                         input logic ui, input logic [DATA_W-1:0] imm);
        in_valid = 1'b1; in_op = op; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd;
        in_use_imm = ui; in_imm = imm;
    endtask

    task automatic issue(input logic [OP_W-1:0] op, input logic [ADDR_W-1:0] rs1,
                         input logic [ADDR_W-1:0] rs2, input logic [ADDR_W-1:0] rd,
                         input logic ui, input logic [DATA_W-1:0] imm);
        drive(op, rs1, rs2, rd, ui, imm);
        #1;
        chk("issue_in_ready", in_ready, 1);
        q.push_back(mk(op, rs1, rs2, rd, ui, imm));
        tick();
        in_valid = 1'b0;
    endtask

    task automatic retire(input string tag);
        total++;
        assert (q.size() > 0) else begin
            bad++;
            $error("FAIL %s_queue observed=empty expected=entry", tag);
        end
        if (q.size() > 0) begin
            cur = q.pop_front();
            chk({tag, "_valid"}, out_valid, 1);
            chk({tag, "_in1"}, alu_in1, cur.in1);
            chk({tag, "_in2"}, alu_in2, cur.in2);
            chk({tag, "_sel"}, alu_sel, cur.sel);
            chk({tag, "_rd"}, out_rd, cur.rd);
            chk({tag, "_dz"}, out_dz, cur.dz);
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
        in_use_imm = 1'b0; in_imm = '0; out_ready = 1'b1; wb_en = 1'b0; wb_addr = '0; wb_data = '0;
        for (int i = 0; i < NREGS; i++) m[i] = '0;
        #2;
        chk("rst_valid", out_valid, 0);
        chk("rst_in1", alu_in1, 0);
        chk("rst_in2", alu_in2, 0);
        chk("rst_sel", alu_sel, 0);
        chk("rst_rd", out_rd, 0);
        chk("rst_dz", out_dz, 0);
        #10 rst_n = 1'b1;
        tick();
        // basic register-register add
        wb(3'd1, 8'h12);
        wb(3'd2, 8'h34);
        issue(OP_ADD, 3'd1, 3'd2, 3'd3, 1'b0, 8'h00);
        retire("add");
        tick();
        chk("add_drain", out_valid, 0);
        // immediate overrides rs2, undefined opcode passes through
        issue(OP_SUB, 3'd1, 3'd2, 3'd4, 1'b1, 8'hFF);
        retire("sub_imm");
        tick();
        issue(5'h1F, 3'd2, 3'd1, 3'd5, 1'b0, 8'h00);
        retire("undef_op");
        tick();
        // backpressure freezes outputs, then back-to-back retire
        out_ready = 1'b0;
        issue(OP_ADD, 3'd1, 3'd2, 3'd4, 1'b0, 8'h00);
        drive(OP_SUB, 3'd2, 3'd1, 3'd5, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) begin
            chk("bp_in_ready", in_ready, 0);
            chk("bp_valid", out_valid, 1);
            chk("bp_in1", alu_in1, q[0].in1);
            chk("bp_sel", alu_sel, q[0].sel);
            chk("bp_rd", out_rd, q[0].rd);
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("b2b_in_ready", in_ready, 1);
        retire("b2b_first");
        q.push_back(mk(OP_SUB, 3'd2, 3'd1, 3'd5, 1'b0, 8'h00));
        tick();
        in_valid = 1'b0;
        retire("b2b_second");
        tick();
        chk("b2b_drain", out_valid, 0);
        // divide-by-zero flag
        wb(3'd2, 8'h00);
        issue(OP_DIV, 3'd1, 3'd2, 3'd1, 1'b0, 8'h00);
        retire("div_zero");
        tick();
        issue(OP_DIV, 3'd1, 3'd2, 3'd1, 1'b1, 8'h01);
        retire("div_imm1");
        tick();
        issue(OP_MUL, 3'd1, 3'd2, 3'd1, 1'b0, 8'h00);
        retire("mul_zero");
        tick();
        // same-cycle writeback to a source register
        drive(OP_ADD, 3'd1, 3'd2, 3'd6, 1'b0, 8'h00);
        wb_en = 1'b1; wb_addr = 3'd1; wb_data = 8'h55;
        m[1] = 8'h55;
        #1;
`ifdef ALU_BYPASS_EN
        chk("fwd_in_ready", in_ready, 1);
        q.push_back(mk(OP_ADD, 3'd1, 3'd2, 3'd6, 1'b0, 8'h00));
        tick();
        wb_en = 1'b0; in_valid = 1'b0;
`else
        chk("stall_in_ready", in_ready, 0);
        tick();
        wb_en = 1'b0;
        #1;
        chk("stall_release", in_ready, 1);
        q.push_back(mk(OP_ADD, 3'd1, 3'd2, 3'd6, 1'b0, 8'h00));
        tick();
        in_valid = 1'b0;
`endif
        retire("wb_hazard");
        tick();
        // asynchronous reset mid-operation
        wb(3'd1, 8'h12);
        out_ready = 1'b0;
        issue(OP_ADD, 3'd1, 3'd2, 3'd7, 1'b0, 8'h00);
        chk("pre_rst_valid", out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_in1", alu_in1, 0);
        chk("arst_in2", alu_in2, 0);
        chk("arst_sel", alu_sel, 0);
        chk("arst_rd", out_rd, 0);
        q.delete();
        for (int i = 0; i < NREGS; i++) m[i] = '0;
        #1 rst_n = 1'b1;
        tick();
        out_ready = 1'b1;
        issue(OP_ADD, 3'd1, 3'd2, 3'd7, 1'b0, 8'h00);
        retire("post_rst_read");
        tick();
        chk("final_drain", out_valid, 0);
        chk("scoreboard_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
